// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code datapath: default width, response FSM encoding, conversion helper.
package gray_pkg;

    localparam int unsigned WIDTH_DEFAULT = 4;
    localparam int unsigned CNT_W_DEFAULT = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    // Zero-extended input keeps the MSB equal to bin's MSB after the shift-XOR.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/bin2gray_comb.sv
// Pure binary-to-Gray conversion of one WIDTH-bit word.
module bin2gray_comb
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray_c
);

    assign gray_c = WIDTH'(bin2gray(32'(bin)));

endmodule

// File: rtl/gray_rr_arbiter.sv
// Two-requester round-robin front end for a shared binary-to-Gray stage with a one-deep response register.
module gray_rr_arbiter
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT,
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_bin,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_bin,
    output logic             req1_ready,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_gray,
    output logic [WIDTH-1:0] rsp_bin,
    output logic             rsp_id,
    input  logic             rsp_ready,
    output logic [CNT_W-1:0] accept_cnt
);

    state_e           state;
    logic             last_grant;
    logic             space_c;
    logic             grant_c;
    logic             accept_c;
    logic [WIDTH-1:0] sel_bin_c;
    logic [WIDTH-1:0] sel_gray_c;

    // On contention the requester that did not win last time is chosen.
    always_comb begin
        grant_c = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_c = ~last_grant;
        end else if (req1_valid) begin
            grant_c = 1'b1;
        end
    end

    assign space_c    = (state == EMPTY) | rsp_ready;
    assign req0_ready = req0_valid & ~grant_c & space_c;
    assign req1_ready = req1_valid &  grant_c & space_c;
    assign accept_c   = req0_ready | req1_ready;
    assign sel_bin_c  = grant_c ? req1_bin : req0_bin;

    bin2gray_comb #(.WIDTH(WIDTH)) u_conv (
        .bin    (sel_bin_c),
        .gray_c (sel_gray_c)
    );

    // Accept takes priority over drain so a simultaneous drain+accept keeps rsp_valid high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= EMPTY;
            rsp_valid  <= 1'b0;
            rsp_gray   <= '0;
            rsp_bin    <= '0;
            rsp_id     <= 1'b0;
            last_grant <= 1'b1;
            accept_cnt <= '0;
        end else if (accept_c) begin
            state      <= FULL;
            rsp_valid  <= 1'b1;
            rsp_gray   <= sel_gray_c;
            rsp_bin    <= sel_bin_c;
            rsp_id     <= grant_c;
            last_grant <= grant_c;
            accept_cnt <= accept_cnt + CNT_W'(1);
        end else if (rsp_valid && rsp_ready) begin
            state      <= EMPTY;
            rsp_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gray_rr_arbiter.sv
// Randomised and directed checking of gray_rr_arbiter against a transaction-level model.
module tb_gray_rr_arbiter;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req1_valid;
    logic [WIDTH-1:0] req0_bin, req1_bin;
    logic             req0_ready, req1_ready;
    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_gray, rsp_bin;
    logic             rsp_id;
    logic             rsp_ready;
    logic [CNT_W-1:0] accept_cnt;

    gray_rr_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_bin   (req0_bin),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_bin   (req1_bin),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_gray   (rsp_gray),
        .rsp_bin    (rsp_bin),
        .rsp_id     (rsp_id),
        .rsp_ready  (rsp_ready),
        .accept_cnt (accept_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Gray sequence built by reflection, independent of any XOR formula.
    int gray_tab [16];

    // Transaction-level model of the response slot
    bit m_valid;
    int m_gray, m_bin, m_id, m_cnt, m_last;
    bit acc0, acc1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_gray  = 0;
        m_bin   = 0;
        m_id    = 0;
        m_cnt   = 0;
        m_last  = 1;
        acc0    = 1'b0;
        acc1    = 1'b0;
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic cycle();
        int  g;
        bit  space;
        bit  r0, r1;
        #1;
        space = !m_valid || (rsp_ready == 1'b1);
        if (req0_valid && req1_valid) g = (m_last == 0) ? 1 : 0;
        else if (req1_valid)          g = 1;
        else if (req0_valid)          g = 0;
        else                          g = -1;
        r0 = (g == 0) && space;
        r1 = (g == 1) && space;
        chk("req0_ready", int'(req0_ready), int'(r0));
        chk("req1_ready", int'(req1_ready), int'(r1));
        @(posedge clk);
        if (r0 || r1) begin
            m_bin   = (g == 1) ? int'(req1_bin) : int'(req0_bin);
            m_gray  = gray_tab[m_bin];
            m_id    = g;
            m_last  = g;
            m_valid = 1'b1;
            m_cnt   = (m_cnt + 1) % 256;
        end else if (m_valid && rsp_ready) begin
            m_valid = 1'b0;
        end
        acc0 = r0;
        acc1 = r1;
        #1;
        chk("rsp_valid",  int'(rsp_valid),  int'(m_valid));
        chk("rsp_gray",   int'(rsp_gray),   m_gray);
        chk("rsp_bin",    int'(rsp_bin),    m_bin);
        chk("rsp_id",     int'(rsp_id),     m_id);
        chk("accept_cnt", int'(accept_cnt), m_cnt);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b0;
        #1;
        model_reset();
        chk("reset_rsp_valid", int'(rsp_valid), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_seq [16];
        logic [3:0] prev_gray;
        logic [3:0] held_gray;

        exp_seq = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                    4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
        gray_tab[0] = 0;
        gray_tab[1] = 1;
        for (int k = 1; k < 4; k++) begin
            for (int i = 0; i < (1 << k); i++) begin
                gray_tab[(1 << k) + i] = gray_tab[(1 << k) - 1 - i] | (1 << k);
            end
        end

        rst        = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_bin   = '0;
        req1_bin   = '0;
        rsp_ready  = 1'b0;
        model_reset();
        #12;
        chk("rst_rsp_valid",  int'(rsp_valid),  0);
        chk("rst_rsp_gray",   int'(rsp_gray),   0);
        chk("rst_rsp_bin",    int'(rsp_bin),    0);
        chk("rst_rsp_id",     int'(rsp_id),     0);
        chk("rst_accept_cnt", int'(accept_cnt), 0);
        @(negedge clk);
        rst = 1'b0;

        // Single request
        req0_valid = 1'b1;
        req0_bin   = 4'b0010;
        rsp_ready  = 1'b1;
        #1 chk("single_req0_ready", int'(req0_ready), 1);
        cycle();
        chk("single_valid", int'(rsp_valid),  1);
        chk("single_gray",  int'(rsp_gray),   3);
        chk("single_bin",   int'(rsp_bin),    2);
        chk("single_id",    int'(rsp_id),     0);
        chk("single_cnt",   int'(accept_cnt), 1);
        req0_valid = 1'b0;
        cycle();

        // Tie after reset, then alternation
        do_reset();
        req0_valid = 1'b1;
        req0_bin   = 4'h5;
        req1_valid = 1'b1;
        req1_bin   = 4'hF;
        rsp_ready  = 1'b1;
        cycle();
        chk("tie1_id",   int'(rsp_id),   0);
        chk("tie1_gray", int'(rsp_gray), 7);
        cycle();
        chk("tie2_id",   int'(rsp_id),   1);
        chk("tie2_gray", int'(rsp_gray), 8);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("alt_id", int'(rsp_id), (i % 2 == 0) ? 0 : 1);
        end

        // Backpressure while FULL (last accept id0)
        req0_valid = 1'b0;
        req1_bin   = 4'hF;
        rsp_ready  = 1'b0;
        held_gray  = rsp_gray;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp_req1_ready", int'(req1_ready), 0);
            chk("bp_gray_hold",  int'(rsp_gray),   int'(held_gray));
        end
        rsp_ready = 1'b1;
        cycle();
        chk("bp_release_id",    int'(rsp_id),    1);
        chk("bp_release_valid", int'(rsp_valid), 1);
        req1_valid = 1'b0;
        cycle();

        // Exhaustive conversion through requester 1
        req1_valid = 1'b1;
        rsp_ready  = 1'b1;
        prev_gray  = '0;
        for (int b = 0; b < 16; b++) begin
            req1_bin = 4'(b);
            cycle();
            chk("seq_gray", int'(rsp_gray), int'(exp_seq[b]));
            if (b > 0) chk("seq_onebit", $countones(rsp_gray ^ prev_gray), 1);
            prev_gray = rsp_gray;
        end

        // Asynchronous reset while FULL
        req1_valid = 1'b0;
        rsp_ready  = 1'b0;
        cycle();
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", int'(rsp_valid),  0);
        chk("async_rst_cnt",   int'(accept_cnt), 0);
        model_reset();
        @(negedge clk);
        rst        = 1'b0;
        req0_valid = 1'b1;
        req0_bin   = 4'h3;
        req1_valid = 1'b1;
        req1_bin   = 4'h6;
        rsp_ready  = 1'b1;
        cycle();
        chk("post_rst_id", int'(rsp_id), 0);

        // Counter wrap
        do_reset();
        req1_valid = 1'b1;
        rsp_ready  = 1'b1;
        for (int i = 0; i < 256; i++) begin
            req1_bin = 4'($urandom_range(0, 15));
            cycle();
        end
        chk("wrap_cnt0", int'(accept_cnt), 0);
        cycle();
        chk("wrap_cnt1", int'(accept_cnt), 1);

        // Randomised traffic honouring the hold-while-pending rule
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            if (!req0_valid || acc0) begin
                req0_valid = 1'($urandom_range(0, 1));
                req0_bin   = 4'($urandom_range(0, 15));
            end
            if (!req1_valid || acc1) begin
                req1_valid = 1'($urandom_range(0, 1));
                req1_bin   = 4'($urandom_range(0, 15));
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
